axis_byte_packer: RTL and testbench
===================================

// Module: axis_byte_packer
// PURPOSE
//   Packs a stream of BITS_PER_WORD-bit bytes from a byte-level UART receiver into one
//   W_OUT-bit AXI-Stream word for the matrix-vector multiplier's kx input (s_axis_kx_*).
//   Double-buffered: the next frame can be assembled while the previous word waits for tready.
//   Flags bytes dropped under backpressure. Optional inter-byte timeout resynchronises framing.
// PARAMETERS
//   BITS_PER_WORD  8       width of one input byte
//   W_OUT          24      output word width; must be an integer multiple of BITS_PER_WORD
//   TIMEOUT_CLKS   52080   idle clocks before a partial frame is discarded (only with timeout macro)
//   NUM_WORDS      derived = W_OUT/BITS_PER_WORD; counter width = max(1,$clog2(NUM_WORDS))
// PORTS
//   clk        in   1              clock, rising edge
//   rstn       in   1              reset, asynchronous, active-low
//   s_valid    in   1              input byte valid; the source cannot stall
//   s_data     in   BITS_PER_WORD  input byte
//   s_ready    out  1              1 = a byte presented this cycle is accepted
//   m_valid    out  1              output word valid (AXI-Stream tvalid)
//   m_data     out  W_OUT          packed word; first received byte in bits [BITS_PER_WORD-1:0]
//   m_ready    in   1              downstream ready (AXI-Stream tready)
//   drop       out  1              1-cycle pulse: s_valid=1 while s_ready=0, byte discarded
//   timeout    out  1              1-cycle pulse: partial frame discarded by timeout
// BEHAVIOUR
//   Reset (async): c_words=0, pending=0, m_valid=0, m_data=0, drop=0, timeout=0, asm=0; s_ready=1.
//   State: c_words (bytes held in the assembly reg asm), pending (asm holds a complete word),
//     and the output slot (m_valid/m_data). s_ready = !pending, driven directly from a register.
//   Accept: s_valid && s_ready. Byte k of a frame is written to asm[k*BPW +: BPW];
//     c_words increments and wraps to 0 after byte NUM_WORDS-1.
//   Slot free this cycle = !m_valid || m_ready.
//   Last byte accepted, slot free: m_data <= {s_data, asm lower bytes}, m_valid <= 1.
//     m_valid is high on the cycle after the edge that accepted the last byte; no extra latency.
//   Last byte accepted, slot busy: the word completes in asm, pending <= 1, s_ready goes low.
//   pending && m_valid && m_ready: m_data <= asm, pending <= 0, m_valid stays 1.
//     Words then leave back-to-back with no bubble.
//   m_valid && m_ready && !pending && no completing byte: m_valid <= 0.
//   Hold rule: m_data is stable while m_valid && !m_ready; m_valid never drops without a handshake.
//   Same-cycle events:
//     - Handshake and last byte on one edge: the new word replaces m_data; m_valid stays 1.
//     - s_valid while pending: byte discarded, drop=1 on the next cycle, counters unchanged.
//   A complete word is never lost. Discarded bytes are reported only through drop.
//   Reset mid-frame: partial frame and any held words are discarded.
//     The next byte after reset is byte 0 of a new frame.
// CONFIGURATION
//   Macro BYTE_PACKER_TIMEOUT_EN:
//   Defined:
//     - Idle counter ($clog2(TIMEOUT_CLKS) bits) is cleared on every accepted byte.
//     - It counts only while c_words!=0 && !pending.
//     - On reaching TIMEOUT_CLKS-1: c_words <= 0, counter <= 0, timeout pulses 1 cycle.
//     - The output slot is untouched.
//   Undefined: no counter is built, timeout is tied to 0, and a partial frame waits indefinitely.
// TESTING  (BITS_PER_WORD=8, W_OUT=24, TIMEOUT_CLKS=100)
//   1 m_ready=1; bytes 11,22,33 -> m_valid one cycle after 3rd byte, m_data=0x332211, then m_valid=0.
//   2 m_ready=0; bytes 01..06 -> m_data=0x030201 held, s_ready=0 after 6th byte.
//     Then byte 07 -> drop pulse. Then m_ready=1 -> 0x030201, then 0x060504 on consecutive cycles.
//   3 First word held; 3rd byte of the next frame arrives on the handshake edge -> m_valid stays 1,
//     next word appears the following cycle, no bubble.
//   4 BYTE_PACKER_TIMEOUT_EN defined; bytes AA,BB, then 100 idle clocks -> timeout pulse.
//     Then bytes 01,02,03 -> m_data=0x030201.
//     Same stimulus with the macro undefined -> 0x01BBAA.
//   5 Bytes 55,66, rstn low 1 cycle mid-frame -> all outputs at reset values.
//     Then bytes 0A,0B,0C -> m_data=0x0C0B0A.

Source files
------------

// File: rtl/axis_byte_packer_if.sv
// axis_byte_packer_if: byte-in / word-out stream bundle. The packer takes the master modport.
`default_nettype none

interface axis_byte_packer_if #(
  parameter int BITS_PER_WORD = 8,
  parameter int W_OUT         = 24
);
  logic                     s_valid;
  logic [BITS_PER_WORD-1:0] s_data;
  logic                     s_ready;
  logic                     m_valid;
  logic [W_OUT-1:0]         m_data;
  logic                     m_ready;

  modport master (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport slave (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

`default_nettype wire

// File: rtl/axis_byte_packer.sv
// +--------------------------------------------------------------------------+
// | axis_byte_packer: packs BITS_PER_WORD-bit bytes into one W_OUT-bit       |
// | AXI-Stream word, double-buffered; optional idle timeout via macro        |
// | BYTE_PACKER_TIMEOUT_EN.                          Revision: 1.0           |
// +--------------------------------------------------------------------------+
`default_nettype none

module axis_byte_packer #(
  parameter int BITS_PER_WORD = 8,
  parameter int W_OUT         = 24,
  parameter int TIMEOUT_CLKS  = 52080
) (
  input  wire                  clk,
  input  wire                  rstn,
  axis_byte_packer_if.master   bus,
  output logic                 drop,
  output logic                 timeout
);

  localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int CW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

  logic [CW-1:0]    c_words;
  logic             pending;
  logic             s_ready_r;
  logic             m_valid_r;
  logic [W_OUT-1:0] m_data_r;
  logic [W_OUT-1:0] asm_r;

  logic             accept;
  logic             last;
  logic             slot_free;
  logic             handshake;
  logic [W_OUT-1:0] full_word;

  assign accept    = bus.s_valid && s_ready_r;
  assign last      = accept && (c_words == LAST_IDX);
  assign slot_free = !m_valid_r || bus.m_ready;
  assign handshake = m_valid_r && bus.m_ready;

  assign bus.s_ready = s_ready_r;
  assign bus.m_valid = m_valid_r;
  assign bus.m_data  = m_data_r;

  // Completed word as it would look with the incoming last byte merged in.
  always_comb begin
    full_word = asm_r;
    full_word[(NUM_WORDS-1)*BITS_PER_WORD +: BITS_PER_WORD] = bus.s_data;
  end

`ifdef BYTE_PACKER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CLKS - 1);

  logic [TW-1:0] idle_cnt;
  logic          idle_hit;

  assign idle_hit = !accept && (c_words != '0) && !pending && (idle_cnt == IDLE_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= idle_hit;
      if (accept || idle_hit)
        idle_cnt <= '0;
      else if ((c_words != '0) && !pending)
        idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  logic idle_hit;
  assign idle_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c_words   <= '0;
      pending   <= 1'b0;
      s_ready_r <= 1'b1;
      m_valid_r <= 1'b0;
      m_data_r  <= '0;
      asm_r     <= '0;
      drop      <= 1'b0;
    end else begin
      drop <= bus.s_valid && !s_ready_r;

      if (accept) begin
        asm_r[c_words*BITS_PER_WORD +: BITS_PER_WORD] <= bus.s_data;
        c_words <= last ? '0 : c_words + 1'b1;
      end else if (idle_hit) begin
        c_words <= '0;
      end

      // No byte is accepted while pending, so the pending drain never races a completion.
      if (pending && handshake) begin
        m_data_r  <= asm_r;
        pending   <= 1'b0;
        s_ready_r <= 1'b1;
      end else if (last && slot_free) begin
        m_data_r  <= full_word;
        m_valid_r <= 1'b1;
      end else if (last) begin
        asm_r     <= full_word;
        pending   <= 1'b1;
        s_ready_r <= 1'b0;
      end else if (handshake) begin
        m_valid_r <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_byte_packer.sv
// tb_axis_byte_packer: directed checks of axis_byte_packer (8-bit bytes, 24-bit words).
`default_nettype none

module tb_axis_byte_packer;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic drop;
  logic timeout;

  int checks = 0;
  int failures = 0;
  int to_seen = 0;

  always #5 clk = ~clk;

  axis_byte_packer_if #(.BITS_PER_WORD(8), .W_OUT(24)) bus ();

  axis_byte_packer #(
    .BITS_PER_WORD(8),
    .W_OUT        (24),
    .TIMEOUT_CLKS (100)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .bus    (bus),
    .drop   (drop),
    .timeout(timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    tick();
    bus.s_valid = 1'b0;
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    tick();
    tick();
    check("rst_s_ready", 32'(bus.s_ready), 32'h1);
    check("rst_m_valid", 32'(bus.m_valid), 32'h0);
    check("rst_m_data", 32'(bus.m_data), 32'h0);
    check("rst_drop", 32'(drop), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    rstn = 1'b1;
    tick();

    // 1: free-flowing word
    bus.m_ready = 1'b1;
    send(8'h11);
    check("t1_no_early_valid", 32'(bus.m_valid), 32'h0);
    send(8'h22);
    send(8'h33);
    check("t1_m_valid", 32'(bus.m_valid), 32'h1);
    check("t1_m_data", 32'(bus.m_data), 32'h332211);
    tick();
    check("t1_m_valid_drop", 32'(bus.m_valid), 32'h0);

    // 2: backpressure, pending word, drop
    bus.m_ready = 1'b0;
    send(8'h01);
    send(8'h02);
    send(8'h03);
    check("t2_word0_valid", 32'(bus.m_valid), 32'h1);
    check("t2_word0_data", 32'(bus.m_data), 32'h030201);
    send(8'h04);
    send(8'h05);
    check("t2_s_ready_before", 32'(bus.s_ready), 32'h1);
    send(8'h06);
    check("t2_s_ready_low", 32'(bus.s_ready), 32'h0);
    check("t2_hold_data", 32'(bus.m_data), 32'h030201);
    send(8'h07);
    check("t2_drop_pulse", 32'(drop), 32'h1);
    check("t2_hold_after_drop", 32'(bus.m_data), 32'h030201);
    tick();
    check("t2_drop_clear", 32'(drop), 32'h0);
    bus.m_ready = 1'b1;
    check("t2_first_out", 32'(bus.m_data), 32'h030201);
    tick();
    check("t2_second_valid", 32'(bus.m_valid), 32'h1);
    check("t2_second_out", 32'(bus.m_data), 32'h060504);
    check("t2_s_ready_back", 32'(bus.s_ready), 32'h1);
    tick();
    check("t2_idle", 32'(bus.m_valid), 32'h0);

    // 3: last byte lands on the handshake edge
    bus.m_ready = 1'b0;
    send(8'hA1);
    send(8'hA2);
    send(8'hA3);
    send(8'hB1);
    send(8'hB2);
    check("t3_held", 32'(bus.m_data), 32'hA3A2A1);
    bus.m_ready = 1'b1;
    send(8'hB3);
    check("t3_valid_stays", 32'(bus.m_valid), 32'h1);
    check("t3_next_word", 32'(bus.m_data), 32'hB3B2B1);
    tick();
    check("t3_idle", 32'(bus.m_valid), 32'h0);

    // 4: inter-byte timeout
    send(8'hAA);
    send(8'hBB);
    for (int i = 0; i < 130; i++) begin
      tick();
      if (timeout) to_seen++;
    end
`ifdef BYTE_PACKER_TIMEOUT_EN
    check("t4_timeout_pulses", 32'(to_seen), 32'h1);
`else
    check("t4_timeout_pulses", 32'(to_seen), 32'h0);
`endif
    send(8'h01);
`ifndef BYTE_PACKER_TIMEOUT_EN
    check("t4_stale_word", 32'(bus.m_data), 32'h01BBAA);
`endif
    send(8'h02);
    send(8'h03);
`ifdef BYTE_PACKER_TIMEOUT_EN
    check("t4_resync_word", 32'(bus.m_data), 32'h030201);
`endif
    tick();

    // 5: reset mid-frame
    send(8'h55);
    send(8'h66);
    rstn = 1'b0;
    tick();
    check("t5_rst_m_valid", 32'(bus.m_valid), 32'h0);
    check("t5_rst_m_data", 32'(bus.m_data), 32'h0);
    check("t5_rst_s_ready", 32'(bus.s_ready), 32'h1);
    rstn = 1'b1;
    tick();
    send(8'h0A);
    send(8'h0B);
    send(8'h0C);
    check("t5_valid", 32'(bus.m_valid), 32'h1);
    check("t5_word", 32'(bus.m_data), 32'h0C0B0A);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
